// File: rtl/apb_gpio_irq_sequencer_if.sv
// APB bus between the interrupt sequencer (master) and the GPIO register slave.
// The master drives the request fields; the slave returns read data, ready and error.
interface apb_gpio_irq_sequencer_if;
  logic        m_psel;
  logic        m_penable;
  logic [3:0]  m_paddr;
  logic        m_pwrite;
  logic [3:0]  m_pstrb;
  logic [31:0] m_pwdata;
  logic [31:0] m_prdata;
  logic        m_pready;
  logic        m_pslverr;

  modport master (
    output m_psel, m_penable, m_paddr, m_pwrite, m_pstrb, m_pwdata,
    input  m_prdata, m_pready, m_pslverr
  );

  modport slave (
    input  m_psel, m_penable, m_paddr, m_pwrite, m_pstrb, m_pwdata,
    output m_prdata, m_pready, m_pslverr
  );
endinterface

// File: rtl/apb_gpio_irq_sequencer.sv
// GPIO irq service: APB read status, W1C clear, push word to a FWFT event FIFO; 5 cycles irq->evt_valid at zero wait.
// Stalls in WAIT_SPACE while the FIFO is full; APB_GPIO_SEQ_TIMEOUT_EN adds an access-phase timeout.

module apb_gpio_irq_sequencer_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     push_vld,
  input  logic [W-1:0]             push_dat,
  output logic                     pop_vld,
  input  logic                     pop_rdy,
  output logic [W-1:0]             pop_dat,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          pop;

  assign pop_vld = (cnt != '0);
  assign pop     = pop_vld & pop_rdy;
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign level   = cnt;
  assign pop_dat = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      case ({push_vld, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end
endmodule

module apb_gpio_irq_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int STAT_ADDR  = 7,
  parameter int HOLDOFF    = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                            PCLK,
  input  logic                            PRESET,
  input  logic                            enable_i,
  input  logic                            irq_i,
  apb_gpio_irq_sequencer_if.master        apb,
  output logic                            evt_valid,
  input  logic                            evt_ready,
  output logic [31:0]                     evt_data,
  output logic [$clog2(FIFO_DEPTH):0]     evt_level,
  output logic                            busy_o,
  output logic                            err_o
);
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_chk
    $error("apb_gpio_irq_sequencer: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    RD_SETUP,
    RD_ACCESS,
    WAIT_SPACE,
    WR_SETUP,
    WR_ACCESS
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [31:0]   stat_q;
  logic [HW-1:0] hold_q;
  logic          err_q;
  logic          cap;
  logic          push;
  logic          set_err;
  logic          fifo_full;
  logic          in_access;
  logic          tmo_hit;

  assign in_access = (state_q == RD_ACCESS) || (state_q == WR_ACCESS);

`ifdef APB_GPIO_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] tmo_cnt;

  // Fires on the last allowed access cycle so psel is high for exactly TIMEOUT access cycles.
  assign tmo_hit = in_access && !apb.m_pready && (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET || !in_access) tmo_cnt <= '0;
    else if (!apb.m_pready)   tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    cap             = 1'b0;
    push            = 1'b0;
    set_err         = 1'b0;
    apb.m_psel      = 1'b0;
    apb.m_penable   = 1'b0;
    apb.m_paddr     = '0;
    apb.m_pwrite    = 1'b0;
    apb.m_pstrb     = '0;
    apb.m_pwdata    = '0;
    case (state_q)
      IDLE: begin
        if (enable_i && irq_i && (hold_q == '0)) state_d = RD_SETUP;
      end
      RD_SETUP: begin
        apb.m_psel  = 1'b1;
        apb.m_paddr = 4'(STAT_ADDR);
        state_d     = RD_ACCESS;
      end
      RD_ACCESS: begin
        apb.m_psel    = 1'b1;
        apb.m_penable = 1'b1;
        apb.m_paddr   = 4'(STAT_ADDR);
        if (apb.m_pready) begin
          cap = 1'b1;
          // Decide on the live read data; stat_q only holds it from the next cycle.
          if (apb.m_pslverr) begin
            set_err = 1'b1;
            state_d = IDLE;
          end else if (apb.m_prdata == '0) begin
            state_d = IDLE;
          end else if (fifo_full) begin
            state_d = WAIT_SPACE;
          end else begin
            state_d = WR_SETUP;
          end
        end else if (tmo_hit) begin
          set_err = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_SPACE: begin
        // Re-read so bits that latched in the GPIO meanwhile get merged.
        if (!fifo_full) state_d = RD_SETUP;
      end
      WR_SETUP: begin
        apb.m_psel   = 1'b1;
        apb.m_paddr  = 4'(STAT_ADDR);
        apb.m_pwrite = 1'b1;
        apb.m_pstrb  = 4'hF;
        apb.m_pwdata = stat_q;
        state_d      = WR_ACCESS;
      end
      WR_ACCESS: begin
        apb.m_psel    = 1'b1;
        apb.m_penable = 1'b1;
        apb.m_paddr   = 4'(STAT_ADDR);
        apb.m_pwrite  = 1'b1;
        apb.m_pstrb   = 4'hF;
        apb.m_pwdata  = stat_q;
        if (apb.m_pready) begin
          if (apb.m_pslverr) set_err = 1'b1;
          else               push    = 1'b1;
          state_d = IDLE;
        end else if (tmo_hit) begin
          set_err = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      stat_q <= '0;
      err_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      if (cap)     stat_q <= apb.m_prdata;
      if (set_err) err_q  <= 1'b1;
      // Holdoff masks the stale irq level still in flight after a clear.
      if (state_q != IDLE && state_d == IDLE)
        hold_q <= HW'(HOLDOFF);
      else if (state_q == IDLE && hold_q != '0)
        hold_q <= hold_q - 1'b1;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign err_o  = err_q;

  apb_gpio_irq_sequencer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_evt_fifo (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .push_vld (push),
    .push_dat (stat_q),
    .pop_vld  (evt_valid),
    .pop_rdy  (evt_ready),
    .pop_dat  (evt_data),
    .level    (evt_level),
    .full     (fifo_full)
  );
endmodule

// File: tb/tb_apb_gpio_irq_sequencer.sv
// Directed bench: a behavioural GPIO status register (W1C, registered irq) answers the sequencer's APB accesses.
module tb_apb_gpio_irq_sequencer;
  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        enable_i;
  logic        irq_q = 1'b0;
  logic        evt_valid;
  logic        evt_ready;
  logic [31:0] evt_data;
  logic [2:0]  evt_level;
  logic        busy_o;
  logic        err_o;

  logic [31:0] status = '0;
  logic [31:0] trig = '0;
  logic [31:0] clr_v;
  logic        pready_en = 1'b1;
  logic        slverr_en = 1'b0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wdata = '0;
  logic [3:0]  last_strb = '0;
  logic [3:0]  last_waddr = '0;
  logic [3:0]  last_raddr = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int rd0;
  int wr0;

  apb_gpio_irq_sequencer_if bus ();

  assign bus.m_prdata  = status;
  assign bus.m_pready  = pready_en;
  assign bus.m_pslverr = slverr_en;

  apb_gpio_irq_sequencer dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .enable_i  (enable_i),
    .irq_i     (irq_q),
    .apb       (bus),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .evt_level (evt_level),
    .busy_o    (busy_o),
    .err_o     (err_o)
  );

  always #5 PCLK = ~PCLK;

  // GPIO model: sticky status, write-1-to-clear, irq registered one cycle behind status.
  always @(posedge PCLK) begin
    clr_v = '0;
    if (bus.m_psel && bus.m_penable && bus.m_pready) begin
      if (bus.m_pwrite) begin
        wr_cnt     <= wr_cnt + 1;
        last_wdata <= bus.m_pwdata;
        last_strb  <= bus.m_pstrb;
        last_waddr <= bus.m_paddr;
        if (!bus.m_pslverr) clr_v = bus.m_pwdata;
      end else begin
        rd_cnt     <= rd_cnt + 1;
        last_raddr <= bus.m_paddr;
      end
    end
    status <= (status & ~clr_v) | trig;
    irq_q  <= |status;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_level(input logic [2:0] lvl, input string tag);
    int k;
    k = 0;
    while (evt_level !== lvl && k < 40) begin
      tick();
      k++;
    end
    check(tag, 32'(evt_level), 32'(lvl));
  endtask

  task automatic fire_and_wait(input logic [31:0] bits, input logic [2:0] lvl, input string tag);
    trig = bits;
    tick();
    trig = '0;
    wait_level(lvl, tag);
    repeat (5) tick();
  endtask

  task automatic pop_one(input logic [31:0] exp, input string tag);
    check(tag, evt_data, exp);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  initial begin
    PRESET    = 1'b1;
    enable_i  = 1'b0;
    evt_ready = 1'b0;
    repeat (2) tick();
    check("rst_psel",    32'(bus.m_psel), 32'h0);
    check("rst_penable", 32'(bus.m_penable), 32'h0);
    check("rst_valid",   32'(evt_valid), 32'h0);
    check("rst_level",   32'(evt_level), 32'h0);
    check("rst_busy",    32'(busy_o), 32'h0);
    check("rst_err",     32'(err_o), 32'h0);
    PRESET   = 1'b0;
    enable_i = 1'b1;
    repeat (3) tick();

    // 1: pin 3 fires, zero-wait service
    trig = 32'h8;
    tick();
    trig = '0;
    tick();
    tick();
    check("t1_rd_setup_psel",   32'(bus.m_psel), 32'h1);
    check("t1_rd_setup_pen",    32'(bus.m_penable), 32'h0);
    check("t1_rd_addr",         32'(bus.m_paddr), 32'h7);
    check("t1_rd_pwrite",       32'(bus.m_pwrite), 32'h0);
    check("t1_rd_pstrb",        32'(bus.m_pstrb), 32'h0);
    tick();
    check("t1_rd_access_pen",   32'(bus.m_penable), 32'h1);
    tick();
    check("t1_wr_setup_pwrite", 32'(bus.m_pwrite), 32'h1);
    check("t1_wr_setup_pen",    32'(bus.m_penable), 32'h0);
    check("t1_wr_pwdata",       bus.m_pwdata, 32'h8);
    check("t1_wr_pstrb",        32'(bus.m_pstrb), 32'hF);
    check("t1_valid_early",     32'(evt_valid), 32'h0);
    tick();
    check("t1_wr_access_pen",   32'(bus.m_penable), 32'h1);
    tick();
    check("t1_idle_psel",       32'(bus.m_psel), 32'h0);
    check("t1_evt_valid",       32'(evt_valid), 32'h1);
    check("t1_evt_data",        evt_data, 32'h8);
    check("t1_evt_level",       32'(evt_level), 32'h1);
    check("t1_status_clr",      status, 32'h0);
    check("t1_waddr",           32'(last_waddr), 32'h7);
    check("t1_raddr",           32'(last_raddr), 32'h7);
    check("t1_ops",             32'(rd_cnt * 16 + wr_cnt), 32'h11);
    pop_one(32'h8, "t1_pop_data");
    check("t1_level_after_pop", 32'(evt_level), 32'h0);
    repeat (4) tick();

    // 2: fill the FIFO, then pin 0 waits for space
    fire_and_wait(32'h10, 3'd1, "t2_fill1");
    fire_and_wait(32'h20, 3'd2, "t2_fill2");
    fire_and_wait(32'h40, 3'd3, "t2_fill3");
    fire_and_wait(32'h80, 3'd4, "t2_fill4");
    rd0  = rd_cnt;
    wr0  = wr_cnt;
    trig = 32'h1;
    tick();
    trig = '0;
    repeat (12) tick();
    check("t2_wait_busy",   32'(busy_o), 32'h1);
    check("t2_wait_psel",   32'(bus.m_psel), 32'h0);
    check("t2_wait_no_wr",  32'(wr_cnt - wr0), 32'h0);
    check("t2_wait_one_rd", 32'(rd_cnt - rd0), 32'h1);
    check("t2_wait_status", status, 32'h1);
    pop_one(32'h10, "t2_pop_head");
    check("t2_level_3",     32'(evt_level), 32'h3);
    wait_level(3'd4, "t2_level_refill");
    check("t2_reread",      32'(rd_cnt - rd0), 32'h2);
    check("t2_one_wr",      32'(wr_cnt - wr0), 32'h1);
    check("t2_wdata",       last_wdata, 32'h1);
    check("t2_status_clr",  status, 32'h0);
    repeat (4) tick();

    // 3: simultaneous push and pop at level 2
    pop_one(32'h20, "t3_pop_a");
    pop_one(32'h40, "t3_pop_b");
    check("t3_level_2", 32'(evt_level), 32'h2);
    trig = 32'h4;
    tick();
    trig = '0;
    repeat (5) tick();
    check("t3_in_wr_access", 32'(bus.m_penable & bus.m_pwrite), 32'h1);
    check("t3_head_before",  evt_data, 32'h80);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("t3_level_same",   32'(evt_level), 32'h2);
    pop_one(32'h1, "t3_order_1");
    check("t3_order_2",      evt_data, 32'h4);
    check("t3_level_1",      32'(evt_level), 32'h1);
    repeat (4) tick();

    // 4: reset during WR_ACCESS
    trig = 32'h200;
    tick();
    trig = '0;
    repeat (4) tick();
    pready_en = 1'b0;
    repeat (2) tick();
    check("t4_stuck_wr", 32'(bus.m_psel & bus.m_penable & bus.m_pwrite), 32'h1);
    PRESET = 1'b1;
    tick();
    check("t4_psel",       32'(bus.m_psel), 32'h0);
    check("t4_penable",    32'(bus.m_penable), 32'h0);
    check("t4_level",      32'(evt_level), 32'h0);
    check("t4_busy",       32'(busy_o), 32'h0);
    check("t4_status_kept", status, 32'h200);
    PRESET    = 1'b0;
    pready_en = 1'b1;
    wait_level(3'd1, "t4_reservice");
    pop_one(32'h200, "t4_evt_data");
    repeat (4) tick();

    // 5: slave error on the read
    slverr_en = 1'b1;
    wr0  = wr_cnt;
    trig = 32'h800;
    tick();
    trig = '0;
    repeat (4) tick();
    slverr_en = 1'b0;
    check("t5_psel",     32'(bus.m_psel), 32'h0);
    check("t5_err",      32'(err_o), 32'h1);
    check("t5_no_push",  32'(evt_level), 32'h0);
    check("t5_no_wr",    32'(wr_cnt - wr0), 32'h0);
    wait_level(3'd1, "t5_later_serviced");
    check("t5_data",     evt_data, 32'h800);
    check("t5_err_sticky", 32'(err_o), 32'h1);
    pop_one(32'h800, "t5_pop");
    repeat (4) tick();
    PRESET = 1'b1;
    tick();
    check("t5_err_cleared", 32'(err_o), 32'h0);
    PRESET = 1'b0;
    repeat (3) tick();

    // 6: pready held low for 20 access cycles
    pready_en = 1'b0;
    trig = 32'h1000;
    tick();
    trig = '0;
    repeat (3) tick();
    repeat (15) tick();
    check("t6_cycle16_psel", 32'(bus.m_psel & bus.m_penable), 32'h1);
    tick();
`ifdef APB_GPIO_SEQ_TIMEOUT_EN
    check("t6_tmo_psel", 32'(bus.m_psel), 32'h0);
    check("t6_tmo_err",  32'(err_o), 32'h1);
    check("t6_tmo_busy", 32'(busy_o), 32'h0);
`else
    check("t6_wait_psel", 32'(bus.m_psel & bus.m_penable), 32'h1);
    check("t6_wait_err",  32'(err_o), 32'h0);
`endif
    check("t6_level", 32'(evt_level), 32'h0);
    repeat (3) tick();
    pready_en = 1'b1;
    wait_level(3'd1, "t6_completes");
    pop_one(32'h1000, "t6_data");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_gpio_irq_sequencer.md
Name: apb_gpio_irq_sequencer

Overview:
Autonomous APB master that services the GPIO block's interrupt without CPU involvement. On irq it performs the following sequence, then hands the event to the host through a valid/ready event FIFO:
- Reads the Trigger Status register.
- Clears exactly the bits read, using write-1-to-clear.
- Pushes the captured status word into the event FIFO.

Sits between the GPIO's irq_o and APB slave port on one side and the host event consumer on the other.

Parameters:
FIFO_DEPTH, 4, event FIFO entries; power of 2, minimum 2.
STAT_ADDR, 7, APB word address of the Trigger Status register.
HOLDOFF, 2, idle cycles after a clear before irq_i is sampled again; covers the registered irq latency.
TIMEOUT, 16, max access-phase cycles waiting for m_pready; used only with the optional feature.

Ports:
PCLK  in  1  clock, rising edge.
PRESET  in  1  synchronous active-high reset.
enable_i  in  1  1 = service interrupts; 0 = stay idle.
irq_i  in  1  GPIO interrupt level.
m_psel  out  1  APB select.
m_penable  out  1  APB enable.
m_paddr  out  4  APB address.
m_pwrite  out  1  APB write.
m_pstrb  out  4  APB byte strobes.
m_pwdata  out  32  APB write data.
m_prdata  in  32  APB read data.
m_pready  in  1  APB ready.
m_pslverr  in  1  APB error.
evt_valid  out  1  FIFO non-empty.
evt_ready  in  1  consumer pop.
evt_data  out  32  head entry: status bits captured.
evt_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
busy_o  out  1  FSM not in IDLE.
err_o  out  1  sticky; set on slave error or timeout; cleared only by PRESET.

Behaviour:
- Reset: PRESET high at a PCLK edge applies the following on that edge, regardless of FSM state or an in-flight APB access:
  - FSM goes to IDLE.
  - All APB outputs go to 0.
  - FIFO is emptied, so evt_valid=0 and evt_level=0.
  - busy_o=0, err_o=0, holdoff counter=0.
- APB protocol: setup cycle with psel=1, penable=0, then access cycles with psel=1, penable=1 until m_pready=1. Address, write, strobe and data are stable across both phases.
- IDLE: moves to RD_SETUP when enable_i=1, irq_i=1 and the holdoff counter is 0.
- RD_SETUP: m_paddr=STAT_ADDR, m_pwrite=0, m_pstrb=0. Goes to RD_ACCESS.
- RD_ACCESS: on m_pready, capture m_prdata into stat_q, then:
  - m_pslverr=1: set err_o, go to IDLE.
  - stat_q==0 (spurious irq): go to IDLE, load holdoff.
  - FIFO full: go to WAIT_SPACE.
  - Otherwise: go to WR_SETUP.
- WAIT_SPACE: the status stays sticky in the GPIO, so no events are lost. When the FIFO is not full, go to RD_SETUP and re-read, so bits accumulated meanwhile are merged.
- WR_SETUP: m_paddr=STAT_ADDR, m_pwrite=1, m_pstrb=4'hF, m_pwdata=stat_q. Goes to WR_ACCESS.
- WR_ACCESS: on m_pready:
  - m_pslverr=1: set err_o, do not push, go to IDLE, load holdoff.
  - Otherwise: push stat_q, go to IDLE, load holdoff.
- Push timing: the push is written on the m_pready edge; evt_valid rises the next cycle.
- Holdoff: the counter loads HOLDOFF on exit to IDLE and decrements to 0 while in IDLE.
- FIFO:
  - First-word-fall-through.
  - Pop when evt_valid & evt_ready.
  - Simultaneous push and pop is legal at any non-empty level and leaves evt_level unchanged.
  - Push never occurs when full, so no overflow exists.
  - Pointers wrap modulo FIFO_DEPTH.
- enable_i=0 mid-sequence: the current sequence completes; no new sequence starts.
- Minimum service time with zero wait states: read 2 cycles, write 2 cycles, then evt_valid on the following cycle.

Optional Feature:
APB_GPIO_SEQ_TIMEOUT_EN
- Defined: a counter runs in RD_ACCESS and WR_ACCESS. If m_pready is still 0 after TIMEOUT access cycles, the FSM:
  - drops psel and penable;
  - sets err_o;
  - does not push;
  - goes to IDLE and loads holdoff.
- Not defined: the FSM waits for m_pready indefinitely; TIMEOUT is unused and no counter logic is built.

Test Plan:
1. Pin 3 rising-edge trigger fires. Expect the APB sequence read 0x7 (prdata=0x00000008), then write 0x7 with pwdata=0x00000008 and pstrb=0xF. Expect evt_data=0x00000008 and evt_level=1; the GPIO status reads 0 afterwards.
2. Fill the FIFO to 4 with evt_ready=0, then fire pin 0. Expect the FSM to sit in WAIT_SPACE with no write issued. Pulse evt_ready for one cycle; expect a re-read, the clear, then evt_level=4.
3. Push and pop in the same cycle at level 2. Expect the level to stay 2 and the entries to come out in order.
4. Assert PRESET during WR_ACCESS. Expect psel=0 and evt_level=0 on the next cycle; the GPIO status is not cleared.
5. Return m_pslverr=1 on the read. Expect err_o=1, no write and no push. A later irq still gets serviced.
6. With APB_GPIO_SEQ_TIMEOUT_EN defined, hold m_pready=0 for 20 cycles. Expect psel to drop after 16 access cycles, err_o=1 and evt_level unchanged.
